fact_accel: RTL and testbench



---
 rtl/fact_accel.sv | 66 ++++++
 tb/tb_fact_accel.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fact_accel.sv
// fact_accel: memory-mapped iterative factorial (CTRL/STATUS/N/RESULT, one multiply per clock); ports clk rst we addr wdata -> rdata irq; `FACT_IRQ_EN adds CTRL.IE and irq=IE&DONE
module fact_accel #(
  parameter int NMAX = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [4:0] NLIM = 5'(NMAX);
  state_t state, state_nx;
  logic [4:0] n, cnt;
  logic [31:0] acc, result;
  logic done, err, ie, sel, wr_ctrl, go, w1c, wr_n, start, err_go, finish;
  logic unused;
  assign unused = ^{addr[31:12], addr[1:0], wdata[31:5]};
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb state_nx = (state == IDLE) ? (start ? BUSY : IDLE) : ((cnt > 5'd1) ? BUSY : IDLE);
  always_comb begin
    sel = (addr[11:4] == 8'd0);
    wr_ctrl = we & sel & (addr[3:2] == 2'd0);
    go = wr_ctrl & wdata[0];
    w1c = we & sel & (addr[3:2] == 2'd1);
    wr_n = we & sel & (addr[3:2] == 2'd2);
    start = go & (state == IDLE) & (n <= NLIM);
    err_go = go & (state == IDLE) & (n > NLIM);
    finish = (state == BUSY) & (cnt <= 5'd1);
    rdata = !sel ? 32'd0 :
            (addr[3:2] == 2'd0) ? {30'd0, ie, 1'b0} :
            (addr[3:2] == 2'd1) ? {29'd0, state == BUSY, err, done} :
            (addr[3:2] == 2'd2) ? {27'd0, n} : result;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      n <= 5'd0;
      cnt <= 5'd0;
      acc <= 32'd0;
      result <= 32'd0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      if (wr_n) n <= wdata[4:0];
      if (start) begin
        cnt <= n;
        acc <= 32'd1;
      end else if (state == BUSY && cnt > 5'd1) begin
        acc <= acc * {27'd0, cnt};
        cnt <= cnt - 5'd1;
      end
      result <= finish ? acc : err_go ? 32'd0 : result;
      done <= (finish | err_go) ? 1'b1 : (start | (w1c & wdata[0])) ? 1'b0 : done;
      err <= err_go ? 1'b1 : (start | (w1c & wdata[1])) ? 1'b0 : err;
    end
  end
`ifdef FACT_IRQ_EN
  always_ff @(posedge clk) ie <= rst ? 1'b0 : wr_ctrl ? wdata[1] : ie;
  assign irq = ie & done;
`else
  assign ie = 1'b0;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_fact_accel.sv
// tb_fact_accel: scoreboard bench for fact_accel against a cycle-count/factorial reference model
module tb_fact_accel;
  logic clk = 0, rst = 1, we = 0, rd_en = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic irq;
  typedef struct {logic [31:0] a; logic [31:0] d; logic q;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [4:0] m_n;
  logic [31:0] m_res, m_jres;
  bit m_done, m_err, m_ie, m_act;
  int m_tdone;
  localparam logic [31:0] B = 32'h3000;

  fact_accel dut (.clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (rd_en) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow addr=%h", addr);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (rdata !== e.d) begin
          n_bad++;
          $display("FAIL rdata addr=%h got=%h exp=%h cyc=%0d", e.a, rdata, e.d, cyc);
        end
        n_cmp++;
        if (irq !== e.q) begin
          n_bad++;
          $display("FAIL irq addr=%h got=%b exp=%b cyc=%0d", e.a, irq, e.q, cyc);
        end
      end
    end
  end

  function automatic logic [31:0] fact(int k);
    longint p = 1;
    for (int i = 2; i <= k; i++) p = p * i;
    return p[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic resolve();
    if (m_act && cyc >= m_tdone) begin
      m_act = 0;
      m_done = 1;
      m_res = m_jres;
    end
  endtask

  task automatic mreset();
    m_n = 0; m_res = 0; m_jres = 0; m_done = 0; m_err = 0; m_ie = 0; m_act = 0; m_tdone = 0;
  endtask

  task automatic rst_pulse();
    rst = 1;
    tick();
    rst = 0;
    mreset();
  endtask

  task automatic idle(int k);
    repeat (k) begin
      tick();
      resolve();
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1; addr = a; wdata = d;
    tick();
    we = 0;
    if (a[11:4] == 8'd0)
      case (a[3:2])
        2'd0: begin
`ifdef FACT_IRQ_EN
          m_ie = d[1];
`endif
          if (d[0] && !m_act) begin
            if (m_n > 5'd12) begin
              m_err = 1; m_done = 1; m_res = 0;
            end else begin
              m_act = 1;
              m_tdone = cyc + (m_n > 5'd1 ? int'(m_n) : 1);
              m_jres = fact(int'(m_n));
              m_done = 0; m_err = 0;
            end
          end
        end
        2'd1: begin
          if (d[0]) m_done = 0;
          if (d[1]) m_err = 0;
        end
        2'd2: m_n = d[4:0];
        default: ;
      endcase
    resolve();
  endtask

  task automatic rd(input logic [31:0] a);
    exp_t e;
    logic [31:0] v;
    case (a[3:2])
      2'd0: v = {30'd0, m_ie, 1'b0};
      2'd1: v = {29'd0, m_act, m_err, m_done};
      2'd2: v = {27'd0, m_n};
      default: v = m_res;
    endcase
    if (a[11:4] != 8'd0) v = 0;
    e.a = a; e.d = v; e.q = m_ie & m_done;
    sb.push_back(e);
    addr = a; rd_en = 1;
    tick();
    rd_en = 0;
    resolve();
  endtask

  task automatic job(input logic [31:0] nv);
    wr(B + 8, nv);
    wr(B, 32'h1);
  endtask

  initial begin
    logic [31:0] base, off, a, r;
    int op;
    mreset();
    tick();
    rst_pulse();
    for (int i = 0; i < 4; i++) rd(B + 32'(i * 4));
    job(5);
    repeat (6) rd(B + 4);
    rd(B + 12);
    job(12);
    idle(11);
    rd(B + 4); rd(B + 4); rd(B + 12);
    job(0);
    rd(B + 4); rd(B + 4); rd(B + 12);
    job(1);
    rd(B + 4); rd(B + 12);
    job(13);
    rd(B + 4); rd(B + 12);
    job(6);
    idle(1);
    wr(B + 8, 3);
    wr(B, 1);
    idle(1);
    rd(B + 4); rd(B + 12); rd(B + 8);
    wr(B, 1);
    idle(3);
    rd(B + 4); rd(B + 12);
    wr(B + 4, 1);
    rd(B + 4);
    job(2);
    idle(1);
    wr(B + 4, 3);
    rd(B + 4);
    wr(B + 32'h10, 32'hFFFF_FFFF);
    rd(B + 32'h10); rd(B + 8); rd(B);
    job(10);
    idle(2);
    rst_pulse();
    rd(B + 4); rd(B + 12);
    wr(B, 2);
    wr(B + 8, 4);
    wr(B, 3);
    idle(3);
    rd(B + 4); rd(B + 4); rd(B);
    wr(B + 4, 1);
    rd(B + 4);
    for (int i = 0; i < 300; i++) begin
      base = 32'h3000 + 32'h1000 * $urandom_range(0, 3);
      off = ($urandom_range(0, 7) == 0) ? ($urandom_range(1, 255) << 4) : 32'd0;
      a = base | off | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      r = $urandom;
      op = $urandom_range(0, 9);
      case (op)
        0, 1: wr(base + 8, (r & ~32'h1f) | $urandom_range(0, 14));
        2: wr(base, r | 32'h1);
        3: wr(base + 4, r);
        4, 5, 6: rd(a);
        7: idle($urandom_range(1, 5));
        8: wr(a, r);
        default: if ($urandom_range(0, 9) == 0) rst_pulse(); else rd(base + 4);
      endcase
    end
    idle(20);
    rd(B + 4); rd(B + 12);
    tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
